// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-subset control unit: decodes IR and sequences fetch, decode, execute,
// memory and write-back steps, stalling on MIO_ready during memory accesses.
module mc_control_fsm (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] Inst,
  input  logic        zero,
  input  logic        overflow,
  input  logic        MIO_ready,
  output logic        IorD,
  output logic        IRWrite,
  output logic [1:0]  RegDst,
  output logic        RegWrite,
  output logic [1:0]  MemtoReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        Branch,
  output logic [3:0]  ALU_operation,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [4:0]  state
);

  typedef enum logic [4:0] {
    StIf   = 5'd0,
    StId   = 5'd1,
    StREx  = 5'd2,
    StRWb  = 5'd3,
    StIEx  = 5'd4,
    StIWb  = 5'd5,
    StMa   = 5'd6,
    StMr   = 5'd7,
    StLwWb = 5'd8,
    StMw   = 5'd9,
    StBr   = 5'd10,
    StJ    = 5'd11,
    StJal  = 5'd12,
    StJrEx = 5'd13,
    StJrPc = 5'd14,
    StLui  = 5'd15
  } state_e;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluXor = 4'b0011;
  localparam logic [3:0] AluNor = 4'b0100;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpXori  = 6'b001110;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [5:0] FnJr  = 6'b001000;
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnXor = 6'b100110;
  localparam logic [5:0] FnNor = 6'b100111;
  localparam logic [5:0] FnSlt = 6'b101010;

  state_e     state_q, state_d;
  logic       ovf_q, ovf_d;
  logic [5:0] opcode, funct;
  logic [3:0] r_op, i_op;
  logic       r_valid, ovf_src;

  // The datapath resolves branches from zero/Branch; the other IR fields are not needed here.
  logic unused_bits;
  assign unused_bits = ^{zero, Inst[25:6]};

  assign opcode = Inst[31:26];
  assign funct  = Inst[5:0];
  assign state  = state_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIf;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    r_op    = AluAdd;
    r_valid = 1'b1;
    case (funct)
      FnAdd:   r_op = AluAdd;
      FnSub:   r_op = AluSub;
      FnAnd:   r_op = AluAnd;
      FnOr:    r_op = AluOr;
      FnXor:   r_op = AluXor;
      FnNor:   r_op = AluNor;
      FnSlt:   r_op = AluSlt;
      default: r_valid = 1'b0;
    endcase

    i_op = AluAdd;
    case (opcode)
      OpSlti:  i_op = AluSlt;
      OpAndi:  i_op = AluAnd;
      OpOri:   i_op = AluOr;
      OpXori:  i_op = AluXor;
      default: i_op = AluAdd;
    endcase

    // Only signed add/subtract can trap; logical and compare ops never suppress the write.
    if (state_q == StREx) begin
      ovf_src = (funct == FnAdd) || (funct == FnSub);
    end else begin
      ovf_src = (opcode == OpAddi);
    end
  end

  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIf: if (MIO_ready) state_d = StId;
      StId: begin
        case (opcode)
          OpRtype:                              state_d = (funct == FnJr) ? StJrEx : StREx;
          OpLw, OpSw:                           state_d = StMa;
          OpBeq, OpBne:                         state_d = StBr;
          OpJ:                                  state_d = StJ;
          OpJal:                                state_d = StJal;
          OpLui:                                state_d = StLui;
          OpAddi, OpSlti, OpAndi, OpOri, OpXori: state_d = StIEx;
          default:                              state_d = StIf;
        endcase
      end
      StREx: begin
        state_d = r_valid ? StRWb : StIf;
        ovf_d   = overflow && ovf_src;
      end
      StIEx: begin
        state_d = StIWb;
        ovf_d   = overflow && ovf_src;
      end
      StMa:    state_d = (opcode == OpLw) ? StMr : StMw;
      StMr:    if (MIO_ready) state_d = StLwWb;
      StMw:    if (MIO_ready) state_d = StIf;
      StJrEx:  state_d = StJrPc;
      StRWb, StIWb, StLwWb, StBr, StJ, StJal, StJrPc, StLui: state_d = StIf;
      default: state_d = StIf;
    endcase
  end

  always_comb begin
    IorD          = 1'b0;
    IRWrite       = 1'b0;
    RegDst        = 2'b00;
    RegWrite      = 1'b0;
    MemtoReg      = 2'b00;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    PCSource      = 2'b00;
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    Branch        = 1'b0;
    ALU_operation = AluAdd;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    unique case (state_q)
      StIf: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = 1'b1;
        IRWrite = MIO_ready;
      end
      StId: ALUSrcB = 2'b11;
      StREx: begin
        ALUSrcA       = 1'b1;
        ALU_operation = r_op;
      end
      StRWb: begin
        RegDst   = 2'b01;
        RegWrite = !ovf_q;
      end
      StIEx: begin
        ALUSrcA       = 1'b1;
        ALUSrcB       = 2'b10;
        ALU_operation = i_op;
      end
      StIWb: RegWrite = !ovf_q;
      StMa: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StMr: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      StLwWb: begin
        MemtoReg = 2'b01;
        RegWrite = 1'b1;
      end
      StMw: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      StBr: begin
        ALUSrcA       = 1'b1;
        ALU_operation = AluSub;
        PCWriteCond   = 1'b1;
        PCSource      = 2'b01;
        Branch        = (opcode == OpBeq);
      end
      StJ: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
      end
      StJal: begin
        RegDst   = 2'b10;
        MemtoReg = 2'b11;
        RegWrite = 1'b1;
        PCSource = 2'b10;
        PCWrite  = 1'b1;
      end
      StJrEx: ALUSrcA = 1'b1;
      StJrPc: begin
        PCSource = 2'b11;
        PCWrite  = 1'b1;
      end
      StLui: begin
        MemtoReg = 2'b10;
        RegWrite = 1'b1;
      end
      default: ;
    endcase

    // Suppress every architectural side effect while reset is held, whatever state we are in.
    if (!reset) begin
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      MemWrite    = 1'b0;
      MemRead     = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized bench for mc_control_fsm: each instruction is expanded into its step sequence
// and every cycle's control word is compared against a table-driven reference.
module tb_mc_control_fsm;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Inst = '0;
  logic        zero = 1'b0, overflow = 1'b0, MIO_ready = 1'b0;
  logic        IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch, MemRead, MemWrite;
  logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
  logic [3:0]  ALU_operation;
  logic [4:0]  state;

  mc_control_fsm dut (
    .clock(clock), .reset(reset), .Inst(Inst), .zero(zero), .overflow(overflow),
    .MIO_ready(MIO_ready), .IorD(IorD), .IRWrite(IRWrite), .RegDst(RegDst),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch),
    .ALU_operation(ALU_operation), .MemRead(MemRead), .MemWrite(MemWrite), .state(state)
  );

  always #5 clock = ~clock;

  localparam int PIf = 0, PId = 1, PREx = 2, PRWb = 3, PIEx = 4, PIWb = 5, PMa = 6, PMr = 7;
  localparam int PLwWb = 8, PMw = 9, PBr = 10, PJ = 11, PJal = 12, PJrEx = 13, PJrPc = 14;
  localparam int PLui = 15;

  string pname [16] = '{"IF", "ID", "R_EX", "R_WB", "I_EX", "I_WB", "MA", "MR", "LW_WB", "MW",
                        "BR", "J", "JAL", "JR_EX", "JR_PC", "LUI"};

  int   checks = 0, failures = 0;
  logic rst_next = 1'b0;

  logic [20:0] obs;
  assign obs = {IorD, IRWrite, RegDst, RegWrite, MemtoReg, ALUSrcA, ALUSrcB, PCSource, PCWrite,
                PCWriteCond, Branch, ALU_operation, MemRead, MemWrite};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected control word per step, straight from the per-state output table.
  function automatic logic [20:0] model_word(int ph, logic [31:0] ins, logic mio, logic ovf,
                                             logic rst);
    logic       iord = 0, irw = 0, rw = 0, a = 0, pcw = 0, pcc = 0, br = 0, mr = 0, mw = 0;
    logic [1:0] rd = 0, m2r = 0, b = 0, pcs = 0;
    logic [3:0] alu = 4'b0010;
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    case (ph)
      PIf:   begin mr = 1; b = 2'b01; pcw = 1; irw = mio; end
      PId:   b = 2'b11;
      PREx: begin
        a = 1;
        case (fn)
          6'h22: alu = 4'b0110;
          6'h24: alu = 4'b0000;
          6'h25: alu = 4'b0001;
          6'h26: alu = 4'b0011;
          6'h27: alu = 4'b0100;
          6'h2A: alu = 4'b0111;
          default: alu = 4'b0010;
        endcase
      end
      PRWb:  begin rd = 2'b01; rw = !ovf; end
      PIEx: begin
        a = 1; b = 2'b10;
        case (op)
          6'h0A: alu = 4'b0111;
          6'h0C: alu = 4'b0000;
          6'h0D: alu = 4'b0001;
          6'h0E: alu = 4'b0011;
          default: alu = 4'b0010;
        endcase
      end
      PIWb:  rw = !ovf;
      PMa:   begin a = 1; b = 2'b10; end
      PMr:   begin iord = 1; mr = 1; end
      PLwWb: begin m2r = 2'b01; rw = 1; end
      PMw:   begin iord = 1; mw = 1; end
      PBr:   begin a = 1; alu = 4'b0110; pcc = 1; pcs = 2'b01; br = (op == 6'h04); end
      PJ:    begin pcs = 2'b10; pcw = 1; end
      PJal:  begin rd = 2'b10; m2r = 2'b11; rw = 1; pcs = 2'b10; pcw = 1; end
      PJrEx: a = 1;
      PJrPc: begin pcs = 2'b11; pcw = 1; end
      PLui:  begin m2r = 2'b10; rw = 1; end
      default: ;
    endcase
    if (!rst) begin irw = 0; rw = 0; pcw = 0; pcc = 0; mw = 0; mr = 0; end
    return {iord, irw, rd, rw, m2r, a, b, pcs, pcw, pcc, br, alu, mr, mw};
  endfunction

  task automatic step(input int ph, input logic [31:0] ins, input logic mio, input logic ovf_in,
                      input logic ovf_flag);
    string tag;
    @(negedge clock);
    reset     = rst_next;
    Inst      = ins;
    MIO_ready = mio;
    overflow  = ovf_in;
    zero      = 1'($urandom_range(0, 1));
    #1;
    tag = $sformatf("%s[%h]", pname[ph], ins);
    check_val(tag, 32'(obs), 32'(model_word(ph, ins, mio, ovf_flag, rst_next)));
    check_val({tag, ".excl"}, 32'(PCWrite & PCWriteCond), 32'd0);
    if (ph == PIf) check_val({tag, ".state"}, 32'(state), 32'd0);
    else if (ph == PId) check_val({tag, ".state"}, 32'(state), 32'd1);
  endtask

  task automatic run_inst(input logic [31:0] ins, input int w_if, input int w_mem,
                          input logic ovf_in);
    int         q[$];
    logic [5:0] op, fn;
    logic       ovf_eff;
    op = ins[31:26];
    fn = ins[5:0];
    ovf_eff = ovf_in && ((op == 6'h00 && (fn == 6'h20 || fn == 6'h22)) || op == 6'h08);
    case (op)
      6'h00: begin
        if (fn == 6'h08) q = '{PJrEx, PJrPc};
        else if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A}) q = '{PREx, PRWb};
        else q = '{PREx};
      end
      6'h23: q = '{PMa, PMr, PLwWb};
      6'h2B: q = '{PMa, PMw};
      6'h04, 6'h05: q = '{PBr};
      6'h02: q = '{PJ};
      6'h03: q = '{PJal};
      6'h0F: q = '{PLui};
      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E: q = '{PIEx, PIWb};
      default: q = {};
    endcase
    for (int k = 0; k <= w_if; k++) step(PIf, ins, k == w_if, 1'($urandom_range(0, 1)), 1'b0);
    step(PId, ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    foreach (q[i]) begin
      if (q[i] == PMr || q[i] == PMw) begin
        for (int k = 0; k <= w_mem; k++) step(q[i], ins, k == w_mem, 1'b0, 1'b0);
      end else if (q[i] == PREx || q[i] == PIEx) begin
        step(q[i], ins, 1'($urandom_range(0, 1)), ovf_in, 1'b0);
      end else begin
        step(q[i], ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ovf_eff);
      end
    end
  endtask

  logic [5:0] r_fns [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
  logic [5:0] i_ops [5] = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E};

  initial begin
    logic [31:0] r, ins;
    int          sel;
    rst_next = 1'b0;
    repeat (3) step(PIf, 32'h0, 1'b1, 1'b0, 1'b0);
    rst_next = 1'b1;

    run_inst(32'h00221820, 0, 0, 1'b0);
    run_inst(32'h00221820, 0, 0, 1'b1);
    run_inst(32'h8C240008, 0, 2, 1'b0);
    run_inst(32'h10220003, 0, 0, 1'b0);
    run_inst(32'h14220003, 1, 0, 1'b0);
    run_inst(32'h0C000010, 0, 0, 1'b0);
    run_inst(32'h03E00008, 0, 0, 1'b0);
    run_inst(32'hFC000000, 0, 0, 1'b0);
    run_inst(32'h20210005, 0, 0, 1'b1);
    run_inst(32'h28210005, 0, 0, 1'b1);
    run_inst(32'h00221824, 0, 0, 1'b1);

    // Reset asserted while a store is waiting on memory.
    step(PIf, 32'hAC240008, 1'b1, 1'b0, 1'b0);
    step(PId, 32'hAC240008, 1'b1, 1'b0, 1'b0);
    step(PMa, 32'hAC240008, 1'b1, 1'b0, 1'b0);
    step(PMw, 32'hAC240008, 1'b0, 1'b0, 1'b0);
    rst_next = 1'b0;
    step(PMw, 32'hAC240008, 1'b0, 1'b0, 1'b0);
    step(PIf, 32'hAC240008, 1'b1, 1'b0, 1'b0);
    rst_next = 1'b1;

    repeat (200) begin
      r   = $urandom();
      sel = $urandom_range(0, 13);
      case (sel)
        0, 1:    ins = {6'h00, r[25:6], r_fns[$urandom_range(0, 6)]};
        2:       ins = {6'h00, r[25:0]};
        3:       ins = {6'h00, r[25:6], 6'h08};
        4:       ins = {6'h23, r[25:0]};
        5:       ins = {6'h2B, r[25:0]};
        6:       ins = {6'h04, r[25:0]};
        7:       ins = {6'h05, r[25:0]};
        8:       ins = {6'h02, r[25:0]};
        9:       ins = {6'h03, r[25:0]};
        10:      ins = {6'h0F, r[25:0]};
        11, 12:  ins = {i_ops[$urandom_range(0, 4)], r[25:0]};
        default: ins = r;
      endcase
      run_inst(ins, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    step(PIf, 32'h0, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
